timer_tick_scheduler: RTL and testbench



---
 rtl/timer_tick_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_timer_tick_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_tick_scheduler.sv
// Avalon-MM master for the 16-bit interval timer. It turns each timer timeout into a tick that
// is shared by N_CH countdown channels. Defining TIMER_TICK_SCHED_SNAP_EN adds a counter-snapshot path.
module timer_tick_scheduler #(
  parameter int          N_CH       = 4,
  parameter int          TICK_W     = 16,
  parameter logic [31:0] DEF_PERIOD = 32'd124999
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic [2:0]               tmr_address,
  output logic                     tmr_chipselect,
  output logic                     tmr_write_n,
  output logic [15:0]              tmr_writedata,
  input  logic [15:0]              tmr_readdata,
  input  logic                     tmr_irq,
  input  logic [31:0]              cfg_period,
  input  logic                     cfg_reprogram,
  input  logic [N_CH-1:0]          arm,
  input  logic [N_CH*TICK_W-1:0]   arm_ticks,
  input  logic [N_CH-1:0]          cancel,
  output logic [N_CH-1:0]          active,
  output logic [N_CH-1:0]          expired,
  output logic [31:0]              tick_count,
  output logic                     ready
`ifdef TIMER_TICK_SCHED_SNAP_EN
  ,
  input  logic                     snap_req,
  output logic                     snap_valid,
  output logic [31:0]              snap_value
`endif
);

  typedef enum logic [3:0] {
    INIT_PL, INIT_PH, INIT_CTL, IDLE, CLR, TICK
`ifdef TIMER_TICK_SCHED_SNAP_EN
    , SNAP_W, SNAP_RL, SNAP_RH
`endif
  } state_t;

  state_t             state_q;
  logic               cs_q, wn_q, ready_q, pend_q;
  logic [2:0]         addr_q;
  logic [15:0]        wd_q;
  logic [31:0]        period_q, cfg_lat_q, tick_q;
  logic [TICK_W-1:0]  cnt_q [N_CH];
  logic [TICK_W-1:0]  cnt_d [N_CH];
  logic [N_CH-1:0]    active_q, active_d, expired_q, expired_d;
  logic               tick_now;
`ifdef TIMER_TICK_SCHED_SNAP_EN
  logic               snap_pend_q;
`endif

  assign tick_now = (state_q == TICK);

  // Bus outputs are registered: the access a state issues appears on the bus in the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= INIT_PL;
      cs_q      <= 1'b0;
      wn_q      <= 1'b1;
      addr_q    <= 3'd0;
      wd_q      <= 16'h0000;
      ready_q   <= 1'b0;
      pend_q    <= 1'b0;
      cfg_lat_q <= 32'h0;
      period_q  <= DEF_PERIOD;
      tick_q    <= 32'h0;
`ifdef TIMER_TICK_SCHED_SNAP_EN
      snap_pend_q <= 1'b0;
`endif
    end else begin
      cs_q   <= 1'b0;
      wn_q   <= 1'b1;
      addr_q <= 3'd0;
      wd_q   <= 16'h0000;
      if (cfg_reprogram) begin
        pend_q    <= 1'b1;
        cfg_lat_q <= cfg_period;
      end
`ifdef TIMER_TICK_SCHED_SNAP_EN
      if (snap_req) snap_pend_q <= 1'b1;
`endif
      case (state_q)
        INIT_PL: begin
          cs_q <= 1'b1; wn_q <= 1'b0; addr_q <= 3'd2; wd_q <= period_q[15:0];
          state_q <= INIT_PH;
        end
        INIT_PH: begin
          cs_q <= 1'b1; wn_q <= 1'b0; addr_q <= 3'd3; wd_q <= period_q[31:16];
          state_q <= INIT_CTL;
        end
        INIT_CTL: begin
          // A period write stops the timer, so the restart is always issued.
          cs_q <= 1'b1; wn_q <= 1'b0; addr_q <= 3'd1; wd_q <= 16'h0007;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        IDLE: begin
          if (tmr_irq) begin
            state_q <= CLR;
          end
`ifdef TIMER_TICK_SCHED_SNAP_EN
          else if (snap_pend_q) begin
            if (!snap_req) snap_pend_q <= 1'b0;
            state_q <= SNAP_W;
          end
`endif
          else if (pend_q) begin
            period_q <= cfg_lat_q;
            if (!cfg_reprogram) pend_q <= 1'b0;
            state_q <= INIT_PL;
          end
        end
        CLR: begin
          cs_q <= 1'b1; wn_q <= 1'b0; addr_q <= 3'd0; wd_q <= 16'h0000;
          state_q <= TICK;
        end
        TICK: begin
          tick_q  <= tick_q + 32'd1;
          state_q <= IDLE;
        end
`ifdef TIMER_TICK_SCHED_SNAP_EN
        SNAP_W: begin
          cs_q <= 1'b1; wn_q <= 1'b0; addr_q <= 3'd4; wd_q <= 16'h0000;
          state_q <= SNAP_RL;
        end
        SNAP_RL: begin
          cs_q <= 1'b1; addr_q <= 3'd4;
          state_q <= SNAP_RH;
        end
        SNAP_RH: begin
          cs_q <= 1'b1; addr_q <= 3'd5;
          state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  // Per channel: cancel beats arm, and arm beats a coincident tick.
  always_comb begin
    active_d  = active_q;
    expired_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      if (cancel[c]) begin
        active_d[c] = 1'b0;
      end else if (arm[c]) begin
        cnt_d[c]     = arm_ticks[c*TICK_W +: TICK_W];
        active_d[c]  = |arm_ticks[c*TICK_W +: TICK_W];
        expired_d[c] = ~|arm_ticks[c*TICK_W +: TICK_W];
      end else if (tick_now && active_q[c]) begin
        cnt_d[c] = cnt_q[c] - 1'b1;
        if (cnt_q[c] == TICK_W'(1)) begin
          active_d[c]  = 1'b0;
          expired_d[c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q  <= '0;
      expired_q <= '0;
      for (int c = 0; c < N_CH; c++) cnt_q[c] <= '0;
    end else begin
      active_q  <= active_d;
      expired_q <= expired_d;
      for (int c = 0; c < N_CH; c++) cnt_q[c] <= cnt_d[c];
    end
  end

`ifdef TIMER_TICK_SCHED_SNAP_EN
  logic        rd_vld_q, snap_vld_q;
  logic [2:0]  rd_addr_q;
  logic [15:0] snap_lo_q;
  logic [31:0] snap_val_q;

  // Read data returns one cycle after the read is on the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q   <= 1'b0;
      rd_addr_q  <= 3'd0;
      snap_lo_q  <= 16'h0;
      snap_vld_q <= 1'b0;
      snap_val_q <= 32'h0;
    end else begin
      rd_vld_q   <= cs_q & wn_q;
      rd_addr_q  <= addr_q;
      snap_vld_q <= 1'b0;
      if (rd_vld_q && rd_addr_q == 3'd4) snap_lo_q <= tmr_readdata;
      if (rd_vld_q && rd_addr_q == 3'd5) begin
        snap_val_q <= {tmr_readdata, snap_lo_q};
        snap_vld_q <= 1'b1;
      end
    end
  end

  assign snap_valid = snap_vld_q;
  assign snap_value = snap_val_q;
`else
  logic unused_rd;
  assign unused_rd = ^tmr_readdata;
`endif

  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wn_q;
  assign tmr_address    = addr_q;
  assign tmr_writedata  = wd_q;
  assign active         = active_q;
  assign expired        = expired_q;
  assign tick_count     = tick_q;
  assign ready          = ready_q;

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Scoreboarded bench for timer_tick_scheduler. A small timer model and directed vectors feed
// expected bus accesses, expiries and snapshots into queues that the monitors drain.
module tb_timer_tick_scheduler;
  localparam int N_CH = 4, TICK_W = 16;

  logic                   clk = 1'b0, reset_n = 1'b0;
  logic [2:0]             tmr_address;
  logic                   tmr_chipselect, tmr_write_n;
  logic [15:0]            tmr_writedata, tmr_readdata = 16'h0;
  logic                   tmr_irq;
  logic [31:0]            cfg_period = 32'h0;
  logic                   cfg_reprogram = 1'b0;
  logic [N_CH-1:0]        arm = '0, cancel = '0;
  logic [N_CH*TICK_W-1:0] arm_ticks = '0;
  logic [N_CH-1:0]        active, expired;
  logic [31:0]            tick_count;
  logic                   ready;
`ifdef TIMER_TICK_SCHED_SNAP_EN
  logic                   snap_req = 1'b0, snap_valid;
  logic [31:0]            snap_value;
`endif

  timer_tick_scheduler #(.N_CH(N_CH), .TICK_W(TICK_W), .DEF_PERIOD(32'd124999)) dut (
    .clk(clk), .reset_n(reset_n),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
    .cfg_period(cfg_period), .cfg_reprogram(cfg_reprogram),
    .arm(arm), .arm_ticks(arm_ticks), .cancel(cancel),
    .active(active), .expired(expired), .tick_count(tick_count), .ready(ready)
`ifdef TIMER_TICK_SCHED_SNAP_EN
    , .snap_req(snap_req), .snap_valid(snap_valid), .snap_value(snap_value)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
  endtask

  typedef struct { int cyc; logic [2:0] addr; logic wn; logic [15:0] dat; } bus_t;
  typedef struct { int cyc; logic [N_CH-1:0] vec; } exp_t;
  typedef struct { int cyc; logic [31:0] val; } snap_t;
  bus_t  bus_q[$];
  exp_t  exp_q[$];
  snap_t snap_q[$];
  bus_t  be;
  exp_t  ee;

  // Timer model: irq is a level raised by the stimulus and dropped by a status write.
  int irq_set_cnt = 0, irq_clr_cnt = 0;
  assign tmr_irq = (irq_set_cnt != irq_clr_cnt);
  logic [31:0] snap_src = 32'h0001_2345, snap_reg = 32'h0;

  always @(negedge clk)
    if (reset_n && tmr_irq && tmr_chipselect && !tmr_write_n && tmr_address == 3'd0)
      irq_clr_cnt = irq_clr_cnt + 1;

  always @(posedge clk) begin
    if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd4) snap_reg <= snap_src;
    if (tmr_chipselect && tmr_write_n)
      tmr_readdata <= (tmr_address == 3'd4) ? snap_reg[15:0] :
                      (tmr_address == 3'd5) ? snap_reg[31:16] : 16'h0;
  end

  logic act1_seen = 1'b0;

  always @(negedge clk) begin
    if (reset_n && active[1]) act1_seen = 1'b1;
    if (reset_n && tmr_chipselect) begin
      if (bus_q.size() == 0) begin
        n_chk++;
        $display("FAIL bus_unexpected: got access addr=%0d wn=%0b data=0x%0h, required none (cycle %0d)",
                 tmr_address, tmr_write_n, tmr_writedata, cyc);
      end else begin
        be = bus_q.pop_front();
        check("bus_cycle", cyc, be.cyc);
        check("bus_addr", tmr_address, be.addr);
        check("bus_write_n", tmr_write_n, be.wn);
        if (!be.wn) check("bus_wdata", tmr_writedata, be.dat);
      end
    end
    if (reset_n && expired != '0) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL exp_unexpected: got expired=%b, required 0 (cycle %0d)", expired, cyc);
      end else begin
        ee = exp_q.pop_front();
        check("exp_cycle", cyc, ee.cyc);
        check("exp_vec", expired, ee.vec);
        check("exp_inactive", active & ee.vec, 0);
      end
    end
  end

`ifdef TIMER_TICK_SCHED_SNAP_EN
  snap_t se;
  always @(negedge clk) begin
    if (reset_n && snap_valid) begin
      if (snap_q.size() == 0) begin
        n_chk++;
        $display("FAIL snap_unexpected: got snap_valid=1, required 0 (cycle %0d)", cyc);
      end else begin
        se = snap_q.pop_front();
        check("snap_cycle", cyc, se.cyc);
        check("snap_value", snap_value, se.val);
      end
    end
  end
`endif

  task automatic push_init(input int base, input logic [31:0] per);
    bus_q.push_back('{base,     3'd2, 1'b0, per[15:0]});
    bus_q.push_back('{base + 1, 3'd3, 1'b0, per[31:16]});
    bus_q.push_back('{base + 2, 3'd1, 1'b0, 16'h0007});
  endtask

  // One timer timeout every 10 cycles; expv is the expiry expected from this tick.
  task automatic do_irq(input logic [N_CH-1:0] expv);
    int m;
    @(posedge clk); #1;
    irq_set_cnt++;
    m = cyc;
    bus_q.push_back('{m + 2, 3'd0, 1'b0, 16'h0000});
    if (expv != '0) exp_q.push_back('{m + 3, expv});
    repeat (9) @(posedge clk);
    #1 check("irq_cleared", tmr_irq, 0);
  endtask

  task automatic do_arm(input int c, input logic [15:0] t, output int n);
    @(posedge clk); #1;
    arm[c] = 1'b1;
    arm_ticks[c*TICK_W +: TICK_W] = t;
    n = cyc;
    @(posedge clk); #1;
    arm = '0;
  endtask

  task automatic do_cancel(input int c);
    @(posedge clk); #1;
    cancel[c] = 1'b1;
    @(posedge clk); #1;
    cancel = '0;
  endtask

  initial begin
    int n, m, k;
    logic ready_low;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", tmr_chipselect, 0);
    check("rst_wn", tmr_write_n, 1);
    check("rst_addr", tmr_address, 0);
    check("rst_wdata", tmr_writedata, 0);
    check("rst_active", active, 0);
    check("rst_expired", expired, 0);
    check("rst_tick", tick_count, 0);
    check("rst_ready", ready, 0);

    // Init sequence with the default period 124999 = 0x1E847
    k = cyc;
    push_init(k + 1, 32'd124999);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_before_ctl", ready, 0);
    @(negedge clk);
    check("ready_after_init", ready, 1);

    // ch0 armed with 3 expires on the third tick
    do_arm(0, 16'd3, n);
    check("ch0_active", active[0], 1);
    do_irq('0);
    do_irq('0);
    do_irq(4'b0001);
    check("tick_after_3", tick_count, 3);
    check("ch0_idle", active[0], 0);

    // ch1 armed with 0 expires next cycle without ever going active
    do_arm(1, 16'd0, n);
    exp_q.push_back('{n + 1, 4'b0010});
    repeat (3) @(posedge clk);
    check("ch1_never_active", act1_seen, 0);

    // ch2 armed with 5, cancelled after 2 ticks, then left to run past its deadline
    do_arm(2, 16'd5, n);
    do_irq('0);
    do_irq('0);
    check("ch2_active", active[2], 1);
    do_cancel(2);
    check("ch2_cancelled", active[2], 0);
    do_irq('0);
    do_irq('0);
    do_irq('0);
    check("tick_after_8", tick_count, 8);

    // irq and reprogram together: tick first, then the reload
    @(posedge clk); #1;
    irq_set_cnt++;
    cfg_reprogram = 1'b1;
    cfg_period = 32'h0001_0000;
    m = cyc;
    bus_q.push_back('{m + 2, 3'd0, 1'b0, 16'h0000});
    push_init(m + 5, 32'h0001_0000);
    @(posedge clk); #1;
    cfg_reprogram = 1'b0;
    ready_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!ready) ready_low = 1'b1;
    end
    check("ready_hold", ready_low, 0);
    check("tick_after_9", tick_count, 9);

    // ch3 armed with 2 in the TICK cycle: that tick does not count
    @(posedge clk); #1;
    irq_set_cnt++;
    m = cyc;
    bus_q.push_back('{m + 2, 3'd0, 1'b0, 16'h0000});
    @(posedge clk); #1;
    @(posedge clk); #1;
    arm[3] = 1'b1;
    arm_ticks[3*TICK_W +: TICK_W] = 16'd2;
    @(posedge clk); #1;
    arm = '0;
    check("ch3_active", active[3], 1);
    repeat (6) @(posedge clk);
    do_irq('0);
    check("ch3_still_active", active[3], 1);
    do_irq(4'b1000);
    check("tick_after_12", tick_count, 12);

    // Reset in the middle of a countdown
    do_arm(0, 16'd5, n);
    do_irq('0);
    check("tick_after_13", tick_count, 13);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_active", active, 0);
    check("mid_rst_tick", tick_count, 0);
    check("mid_rst_ready", ready, 0);
    check("mid_rst_cs", tmr_chipselect, 0);
    @(negedge clk);
    k = cyc;
    push_init(k + 1, 32'd124999);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_after_reinit", ready, 1);
    do_irq('0);
    check("tick_after_reinit", tick_count, 1);

`ifdef TIMER_TICK_SCHED_SNAP_EN
    @(posedge clk); #1;
    snap_req = 1'b1;
    n = cyc;
    bus_q.push_back('{n + 3, 3'd4, 1'b0, 16'h0000});
    bus_q.push_back('{n + 4, 3'd4, 1'b1, 16'h0000});
    bus_q.push_back('{n + 5, 3'd5, 1'b1, 16'h0000});
    snap_q.push_back('{n + 7, 32'h0001_2345});
    @(posedge clk); #1;
    snap_req = 1'b0;
    repeat (12) @(posedge clk);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("bus_q_drained", bus_q.size(), 0);
    check("exp_q_drained", exp_q.size(), 0);
    check("snap_q_drained", snap_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
